// File: rtl/pc_fetch_unit.sv
// Fetch stage: drives ROM address, captures word into ir, handles GOTO/CALL/RETURN/skip with an 8-deep return stack.
// Latency: ir = mem[addr] one edge after addr is presented; each taken redirect costs one bubble; stall freezes all state.
module pc_fetch_unit #(
    parameter int                    PC_WIDTH     = 13,
    parameter int                    INST_WIDTH   = 14,
    parameter int                    STACK_LOG2   = 3,
    parameter logic [PC_WIDTH-1:0]   RESET_VECTOR = 13'h0000,
    parameter logic [INST_WIDTH-1:0] NOP_WORD     = 14'h0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    output logic [PC_WIDTH-1:0]   imem_addr,
    input  logic [INST_WIDTH-1:0] imem_data,
    input  logic                  jump,
    input  logic                  call,
    input  logic                  ret,
    input  logic                  skip,
    input  logic [10:0]           target,
    input  logic [1:0]            pclath,
    output logic [INST_WIDTH-1:0] ir,
    output logic                  ir_valid,
    output logic [PC_WIDTH-1:0]   pc,
    output logic [STACK_LOG2:0]   stack_depth,
    output logic                  stack_overflow,
    output logic                  stack_underflow
);

    localparam int                  DEPTH      = 1 << STACK_LOG2;
    localparam logic [STACK_LOG2:0] DEPTH_FULL = (STACK_LOG2 + 1)'(DEPTH);

    logic [PC_WIDTH-1:0]   apc;
    logic [STACK_LOG2-1:0] ptr;
    logic [STACK_LOG2-1:0] ptr_dec;
    logic [PC_WIDTH-1:0]   stack_mem [DEPTH];

    logic active;
    logic do_ret;
    logic do_call;
    logic do_jump;
    logic do_skip;
    logic redirect;

    // Controls belong to the word in ir, so a bubble or a stalled cycle never acts on them.
    assign active   = ir_valid & ~stall & ~reset;
    assign do_ret   = active & ret;
    assign do_call  = active & call & ~ret;
    assign do_jump  = active & jump & ~ret & ~call;
    assign do_skip  = active & skip & ~ret & ~call & ~jump;
    assign redirect = do_ret | do_call | do_jump;
    assign ptr_dec  = ptr - STACK_LOG2'(1);

    always_comb begin
        imem_addr = apc + PC_WIDTH'(1);
        if (reset) begin
            imem_addr = RESET_VECTOR;
        end else if (stall) begin
            imem_addr = apc;
        end else if (do_ret) begin
            imem_addr = stack_mem[ptr_dec];
        end else if (do_call || do_jump) begin
            imem_addr = PC_WIDTH'({pclath, target});
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            apc             <= RESET_VECTOR;
            ir              <= NOP_WORD;
            ir_valid        <= 1'b0;
            pc              <= '0;
            ptr             <= '0;
            stack_depth     <= '0;
            stack_overflow  <= 1'b0;
            stack_underflow <= 1'b0;
        end else if (!stall) begin
            apc <= imem_addr;
            if (redirect) begin
                ir       <= NOP_WORD;
                ir_valid <= 1'b0;
            end else begin
                pc       <= apc;
                ir       <= do_skip ? NOP_WORD : imem_data;
                ir_valid <= ~do_skip;
            end
            // Stack pointer always wraps; depth saturates and the sticky flags record the abuse.
            if (do_call) begin
                ptr <= ptr + STACK_LOG2'(1);
                if (stack_depth == DEPTH_FULL) begin
                    stack_overflow <= 1'b1;
                end else begin
                    stack_depth <= stack_depth + (STACK_LOG2 + 1)'(1);
                end
            end else if (do_ret) begin
                ptr <= ptr_dec;
                if (stack_depth == '0) begin
                    stack_underflow <= 1'b1;
                end else begin
                    stack_depth <= stack_depth - (STACK_LOG2 + 1)'(1);
                end
            end
        end
    end

    // Stack contents survive reset; only the pointer and depth are cleared.
    always_ff @(posedge clk) begin
        if (do_call) begin
            stack_mem[ptr] <= pc + PC_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: registered ROM model (word n = n) and a per-cycle expectation queue.
module tb_pc_fetch_unit;

    localparam logic [13:0] NOP = 14'h0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        jump;
    logic        call;
    logic        ret;
    logic        skip;
    logic [10:0] target;
    logic [1:0]  pclath;
    logic [12:0] imem_addr;
    logic [13:0] imem_data;
    logic [13:0] ir;
    logic        ir_valid;
    logic [12:0] pc;
    logic [3:0]  stack_depth;
    logic        stack_overflow;
    logic        stack_underflow;

    int    checks = 0;
    int    errors = 0;
    string phase  = "init";

    typedef struct packed {
        logic        v;
        logic [12:0] pc;
    } exp_t;

    exp_t sb[$];

    pc_fetch_unit dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .imem_addr       (imem_addr),
        .imem_data       (imem_data),
        .jump            (jump),
        .call            (call),
        .ret             (ret),
        .skip            (skip),
        .target          (target),
        .pclath          (pclath),
        .ir              (ir),
        .ir_valid        (ir_valid),
        .pc              (pc),
        .stack_depth     (stack_depth),
        .stack_overflow  (stack_overflow),
        .stack_underflow (stack_underflow)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] rom(input logic [12:0] a);
        return {1'b0, a};
    endfunction

    always_ff @(posedge clk) imem_data <= rom(imem_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s/%s: got 0x%0h expected 0x%0h", phase, tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push the expected ir state for the coming edge, clock it, then pop and score.
    task automatic expect_cycle(input logic v, input logic [12:0] p);
        exp_t e;
        sb.push_back('{v: v, pc: p});
        tick();
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("ir_valid", 32'(ir_valid), 32'(e.v));
            check("pc", 32'(pc), 32'(e.pc));
            check("ir", 32'(ir), 32'(e.v ? rom(e.pc) : NOP));
        end
    endtask

    task automatic check_reset_state();
        check("rst_ir", 32'(ir), 32'(NOP));
        check("rst_ir_valid", 32'(ir_valid), 32'd0);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_depth", 32'(stack_depth), 32'd0);
        check("rst_overflow", 32'(stack_overflow), 32'd0);
        check("rst_underflow", 32'(stack_underflow), 32'd0);
        check("rst_imem_addr", 32'(imem_addr), 32'd0);
    endtask

    initial begin
        logic [12:0] cur;
        logic [12:0] ra;

        reset  = 1'b1;
        stall  = 1'b0;
        jump   = 1'b0;
        call   = 1'b0;
        ret    = 1'b0;
        skip   = 1'b0;
        target = '0;
        pclath = '0;

        phase = "reset";
        tick();
        tick();
        check_reset_state();
        reset = 1'b0;

        phase = "seq";
        for (int n = 0; n < 6; n++) expect_cycle(1'b1, 13'(n));

        phase = "goto";
        jump = 1'b1; pclath = 2'b01; target = 11'h010;
        expect_cycle(1'b0, 13'h0005);
        jump = 1'b0;
        expect_cycle(1'b1, 13'h0810);
        expect_cycle(1'b1, 13'h0811);

        phase = "call";
        jump = 1'b1; pclath = 2'b00; target = 11'h020;
        expect_cycle(1'b0, 13'h0811);
        jump = 1'b0;
        expect_cycle(1'b1, 13'h0020);
        call = 1'b1; target = 11'h100;
        expect_cycle(1'b0, 13'h0020);
        call = 1'b0;
        check("call_depth", 32'(stack_depth), 32'd1);
        expect_cycle(1'b1, 13'h0100);
        expect_cycle(1'b1, 13'h0101);
        ret = 1'b1;
        expect_cycle(1'b0, 13'h0101);
        ret = 1'b0;
        check("ret_depth", 32'(stack_depth), 32'd0);
        expect_cycle(1'b1, 13'h0021);

        phase = "skip";
        jump = 1'b1; target = 11'h007;
        expect_cycle(1'b0, 13'h0021);
        jump = 1'b0;
        expect_cycle(1'b1, 13'h0007);
        skip = 1'b1;
        expect_cycle(1'b0, 13'h0008);
        skip = 1'b0;
        expect_cycle(1'b1, 13'h0009);
        check("skip_depth", 32'(stack_depth), 32'd0);

        phase = "overflow";
        cur = 13'h0009;
        for (int k = 0; k < 9; k++) begin
            call = 1'b1; pclath = 2'b00; target = 11'(32'h200 + 16 * k);
            expect_cycle(1'b0, cur);
            call = 1'b0;
            check("depth", 32'(stack_depth), (k < 8) ? 32'(k + 1) : 32'd8);
            check("overflow_flag", 32'(stack_overflow), (k == 8) ? 32'd1 : 32'd0);
            cur = 13'(32'h200 + 16 * k);
            expect_cycle(1'b1, cur);
        end

        phase = "underflow";
        for (int i = 1; i <= 9; i++) begin
            ret = 1'b1;
            expect_cycle(1'b0, cur);
            ret = 1'b0;
            check("depth", 32'(stack_depth), (i < 8) ? 32'(8 - i) : 32'd0);
            check("underflow_flag", 32'(stack_underflow), (i == 9) ? 32'd1 : 32'd0);
            ra = (i == 9) ? 13'h0271 : 13'(32'h200 + 16 * (8 - i) + 1);
            expect_cycle(1'b1, ra);
            cur = ra;
        end

        phase = "stall";
        expect_cycle(1'b1, 13'h0272);
        stall = 1'b1; jump = 1'b1; pclath = 2'b10; target = 11'h055;
        #1;
        check("stall_imem_addr", 32'(imem_addr), 32'h0273);
        repeat (3) begin
            expect_cycle(1'b1, 13'h0272);
            check("stall_imem_addr", 32'(imem_addr), 32'h0273);
        end
        stall = 1'b0;
        #1;
        check("jump_imem_addr", 32'(imem_addr), 32'h1055);
        skip = 1'b1;
        expect_cycle(1'b0, 13'h0272);
        expect_cycle(1'b1, 13'h1055);
        jump = 1'b0; skip = 1'b0;
        expect_cycle(1'b1, 13'h1056);

        phase = "wrap";
        jump = 1'b1; pclath = 2'b11; target = 11'h7FE;
        expect_cycle(1'b0, 13'h1056);
        jump = 1'b0;
        expect_cycle(1'b1, 13'h1FFE);
        expect_cycle(1'b1, 13'h1FFF);
        expect_cycle(1'b1, 13'h0000);

        phase = "reset_in_stall";
        stall = 1'b1; reset = 1'b1;
        tick();
        check_reset_state();
        reset = 1'b0; stall = 1'b0;
        expect_cycle(1'b1, 13'h0000);
        expect_cycle(1'b1, 13'h0001);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Instruction-fetch stage that sits directly upstream of the instruction decoder. It generates the 13-bit program address for the registered instruction ROM (1-cycle read latency) and captures the returned 14-bit word into an instruction register for the decoder. It implements sequential fetch, GOTO, CALL and RETURN through an 8-entry return stack, and conditional skip (DECFSZ/INCFSZ/BTFSx). Taken redirects and skips squash the in-flight word, and squashed words are replaced by a NOP bubble.

Parameters:
PC_WIDTH, 13, program address width
INST_WIDTH, 14, instruction width
STACK_LOG2, 3, log2 of return-stack depth (8 entries)
RESET_VECTOR, 13'h0000, first fetch address after reset
NOP_WORD, 14'h0000, word placed in ir for a bubble

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
stall  in  1  hold all fetch state this cycle
imem_addr  out  13  combinational address to instruction ROM, sampled by ROM at posedge
imem_data  in  14  ROM output; equals mem[address sampled at previous edge]
jump  in  1  GOTO for the instruction in ir
call  in  1  CALL for the instruction in ir
ret  in  1  RETURN/RETLW for the instruction in ir
skip  in  1  skip the next instruction (the in-flight word)
target  in  11  jump/call target low bits
pclath  in  2  jump/call target high bits
ir  out  14  instruction register to decoder
ir_valid  out  1  ir holds a real instruction (0 = bubble)
pc  out  13  address of the instruction in ir
stack_depth  out  4  valid entries, 0..8
stack_overflow  out  1  sticky: a push occurred at depth 8
stack_underflow  out  1  sticky: a pop occurred at depth 0

Behaviour:
- Internal register apc holds the address whose data is currently on imem_data.
- Control inputs (jump/call/ret/skip) are honoured only when ir_valid=1 and stall=0; otherwise they are ignored.
- Priority: reset > stall > ret > call > jump > skip > sequential. At most one redirect acts per cycle.
- imem_addr selection:
  - reset: RESET_VECTOR
  - stall: apc (re-read, so data stays stable)
  - ret: top of stack
  - call/jump: {pclath,target}
  - otherwise: apc+1, wrapping 0x1FFF->0x0000
- On every non-reset, non-stall edge, apc <= imem_addr.
- Sequential or skip edge:
  - pc <= apc
  - ir <= imem_data, ir_valid <= 1, except on skip: ir <= NOP_WORD, ir_valid <= 0, and pc is still updated.
- Redirect edge (ret/call/jump): ir <= NOP_WORD, ir_valid <= 0, pc unchanged. Each taken redirect costs exactly one bubble. The target instruction appears in ir at the second edge after the redirect.
- Stall: apc, ir, ir_valid, pc and the stack all hold; imem_addr = apc.
- Return stack: 8 x 13 bits, pointer ptr in 0..7.
  - call pushes pc+1 (wrapping): stack[ptr] <= pc+1, ptr <= ptr+1.
  - ret pops and reads stack[ptr-1]: ptr <= ptr-1.
  - stack_depth saturates at 8 on push and at 0 on pop.
- Overflow: a push at depth 8 still writes and wraps ptr, overwriting the oldest entry. It sets stack_overflow; depth stays 8.
- Underflow: a pop at depth 0 still returns stack[ptr-1] and wraps ptr. It sets stack_underflow; depth stays 0.
- Sticky flags clear only on reset.
- Reset (synchronous):
  - ir = NOP_WORD, ir_valid = 0, pc = 0, apc = RESET_VECTOR
  - ptr = 0, stack_depth = 0, both flags = 0
  - Stack contents are not cleared.
  - Reset mid-redirect or mid-stall discards all pending state.
- Post-reset latency: reset must be held for at least 1 cycle. At the first edge after reset deasserts, ir = mem[RESET_VECTOR] and ir_valid = 1.

Test Plan:
- Reset then free run, ROM word n = n: ir = 0,1,2,3 on consecutive cycles; pc tracks ir; ir_valid=1 from the first post-reset edge.
- GOTO: with ir at pc=5, assert jump, pclath=2'b01, target=0x010 -> one bubble (ir_valid=0), then pc=0x0810 and ir=mem[0x0810], then 0x0811.
- CALL at pc=0x020 to 0x100, then RETURN at 0x101 -> stack_depth 1->0; the instruction after the return bubble has pc=0x021.
- Skip at pc=7 -> next cycle ir_valid=0 with pc=8; following cycle pc=9 and ir=mem[9]; stack unaffected.
- Nine nested CALLs -> stack_overflow=1 on the ninth, depth=8; nine RETs -> the ninth returns the overwritten-entry value and sets stack_underflow=1, depth=0.
- Stall for 3 cycles while jump is asserted -> ir, pc and imem_addr are frozen and the jump is not taken until stall drops; jump/skip asserted during a bubble (ir_valid=0) has no effect.
